// File: rtl/breakout_game_ctrl.sv
// Top-level breakout game sequencer: idle/serve/play/pause/win/end with lives,
// level progression and single-cycle reset pulses toward the game components.
module breakout_game_ctrl #(
    parameter int unsigned IDLE_DELAY  = 1000000,
    parameter int unsigned SERVE_DELAY = 500000,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned LEVELS      = 4,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned LIFE_W      = $clog2(LIVES + 1),
    parameter int unsigned LVL_W       = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start_key,
    input  logic              i_pause_key,
    input  logic              i_lose_sig,
    input  logic              i_clear_sig,
    output logic [2:0]        o_game_state,
    output logic              o_game_reset,
    output logic              o_ball_reset,
    output logic              o_level_up,
    output logic              o_play_en,
    output logic [LIFE_W-1:0] o_lives_left,
    output logic [LVL_W-1:0]  o_level
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPause = 3'd3,
        StWin   = 3'd4,
        StEnd   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0]  IDLE_CNT  = CNT_W'(IDLE_DELAY);
    localparam logic [CNT_W-1:0]  SERVE_CNT = CNT_W'(SERVE_DELAY);
    localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0] LAST_LIFE  = LIFE_W'(1);
    localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(LEVELS - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [LIFE_W-1:0]   r_lives;
    logic [LVL_W-1:0]    r_level;
    logic                r_game_reset;
    logic                r_ball_reset;
    logic                r_level_up;
    logic                r_play_en;

    state_t              w_state_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [CNT_W-1:0]    w_cnt_lim;
    logic [LIFE_W-1:0]   w_lives_d;
    logic [LVL_W-1:0]    w_level_d;
    logic                w_game_reset_d;
    logic                w_ball_reset_d;
    logic                w_level_up_d;
    logic                w_delay_done;

    // Only IDLE and SERVE are timed; other states park the counter at 0.
    always_comb begin
        w_cnt_lim = '0;
        if (r_state == StIdle) begin
            w_cnt_lim = IDLE_CNT;
        end else if (r_state == StServe) begin
            w_cnt_lim = SERVE_CNT;
        end
    end

    assign w_delay_done = ((r_state == StIdle) || (r_state == StServe)) &&
                          (r_cnt == w_cnt_lim);

    always_comb begin
        w_state_d      = r_state;
        w_lives_d      = r_lives;
        w_level_d      = r_level;
        w_game_reset_d = 1'b0;
        w_ball_reset_d = 1'b0;
        w_level_up_d   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_delay_done && i_start_key) begin
                    w_state_d      = StServe;
                    w_game_reset_d = 1'b1;
                    w_ball_reset_d = 1'b1;
                    w_lives_d      = LIVES_INIT;
                    w_level_d      = '0;
                end
            end
            StServe: begin
                if (w_delay_done) begin
                    w_state_d = StPlay;
                end
            end
            StPlay: begin
                // Losing the ball outranks clearing the field, which outranks pause.
                if (i_lose_sig) begin
                    if (r_lives == LAST_LIFE) begin
                        w_state_d      = StEnd;
                        w_lives_d      = '0;
                        w_game_reset_d = 1'b1;
                    end else begin
                        w_state_d      = StServe;
                        w_lives_d      = r_lives - LAST_LIFE;
                        w_ball_reset_d = 1'b1;
                    end
                end else if (i_clear_sig) begin
                    if (r_level == LAST_LEVEL) begin
                        w_state_d      = StWin;
                        w_game_reset_d = 1'b1;
                    end else begin
                        w_state_d      = StServe;
                        w_level_d      = r_level + LVL_W'(1);
                        w_ball_reset_d = 1'b1;
                        w_level_up_d   = 1'b1;
                    end
                end else if (i_pause_key) begin
                    w_state_d = StPause;
                end
            end
            StPause: begin
                if (i_pause_key) begin
                    w_state_d = StPlay;
                end
            end
            StWin, StEnd: begin
                if (i_start_key) begin
                    w_state_d      = StIdle;
                    w_game_reset_d = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_cnt_d = r_cnt;
        if (w_state_d != r_state) begin
            w_cnt_d = '0;
        end else if (r_cnt != w_cnt_lim) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_lives      <= LIVES_INIT;
            r_level      <= '0;
            r_game_reset <= 1'b0;
            r_ball_reset <= 1'b0;
            r_level_up   <= 1'b0;
            r_play_en    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_lives      <= w_lives_d;
            r_level      <= w_level_d;
            r_game_reset <= w_game_reset_d;
            r_ball_reset <= w_ball_reset_d;
            r_level_up   <= w_level_up_d;
            r_play_en    <= (w_state_d == StPlay);
        end
    end

    assign o_game_state = r_state;
    assign o_game_reset = r_game_reset;
    assign o_ball_reset = r_ball_reset;
    assign o_level_up   = r_level_up;
    assign o_play_en    = r_play_en;
    assign o_lives_left = r_lives;
    assign o_level      = r_level;

endmodule
